// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: fetches opcode and operand bytes, then drives ALU, store and jump control.
// Optional single-step pause after each executed instruction is enabled by defining SEQ_STEP_EN.
module instr_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] mem_rdata,
    input  logic       mem_ready,
    input  logic [7:0] alu_res,
    input  logic       step,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic [7:0] mem_addr,
    output logic [7:0] opr,
    output logic [1:0] alu_op,
    output logic       acc_we,
    output logic       jmp,
    output logic       pc_inc,
    output logic [7:0] pc,
    output logic       halted
);

    typedef enum logic [2:0] {
        FETCH,
        FETCH2,
        EXEC,
`ifdef SEQ_STEP_EN
        PAUSE,
`endif
        HALT
    } state_t;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_LDI  = 4'h1,
        OP_ADDI = 4'h2,
        OP_SUBI = 4'h3,
        OP_STA  = 4'h4,
        OP_JMP  = 4'h5,
        OP_JNZ  = 4'h6,
        OP_HLT  = 4'hF
    } opcode_t;

`ifdef SEQ_STEP_EN
    localparam state_t EXEC_DONE = PAUSE;
`else
    localparam state_t EXEC_DONE = FETCH;
`endif

    state_t     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] ir_q, ir_d;
    logic [7:0] opr_q, opr_d;
    logic       unused_ok;

    // Low opcode nibble carries no meaning; step is only consumed when pausing is built in.
    assign unused_ok = ^{ir_q[3:0], step};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            pc_q    <= 8'h00;
            ir_q    <= 8'h00;
            opr_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            opr_q   <= opr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        opr_d    = opr_q;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        mem_addr = pc_q;
        alu_op   = 2'b11;
        acc_we   = 1'b0;
        jmp      = 1'b0;

        case (state_q)
            FETCH: begin
                mem_rd = 1'b1;
                if (mem_ready) begin
                    ir_d = mem_rdata;
                    pc_d = pc_q + 8'd1;
                    if (mem_rdata[7:4] >= 4'h1 && mem_rdata[7:4] <= 4'h6)
                        state_d = FETCH2;
                    else
                        state_d = EXEC;
                end
            end
            FETCH2: begin
                mem_rd = 1'b1;
                if (mem_ready) begin
                    opr_d   = mem_rdata;
                    pc_d    = pc_q + 8'd1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = EXEC_DONE;
                case (ir_q[7:4])
                    OP_LDI: begin
                        alu_op = 2'b00;
                        acc_we = 1'b1;
                    end
                    OP_ADDI: begin
                        alu_op = 2'b01;
                        acc_we = 1'b1;
                    end
                    OP_SUBI: begin
                        alu_op = 2'b10;
                        acc_we = 1'b1;
                    end
                    OP_STA: begin
                        mem_wr   = 1'b1;
                        mem_addr = opr_q;
                        if (!mem_ready)
                            state_d = EXEC;
                    end
                    OP_JMP: begin
                        jmp  = 1'b1;
                        pc_d = opr_q;
                    end
                    OP_JNZ: begin
                        if (alu_res != 8'h00) begin
                            jmp  = 1'b1;
                            pc_d = opr_q;
                        end
                    end
                    OP_HLT: state_d = HALT;
                    default: ;
                endcase
            end
`ifdef SEQ_STEP_EN
            PAUSE: begin
                if (step)
                    state_d = FETCH;
            end
`endif
            HALT: ;
            default: state_d = FETCH;
        endcase

        // While reset is held, no request or pulse may leak out of the freshly reset FETCH state.
        if (rst) begin
            mem_rd = 1'b0;
            mem_wr = 1'b0;
            acc_we = 1'b0;
            jmp    = 1'b0;
            alu_op = 2'b11;
        end
    end

    assign pc     = pc_q;
    assign opr    = opr_q;
    assign pc_inc = ~jmp;
    assign halted = (state_q == HALT);

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: an instruction-level model predicts every bus cycle and control pulse.
// Build with SEQ_STEP_EN defined to exercise the single-step pause.
module tb_instr_sequencer;

    logic       clk;
    logic       rst;
    logic [7:0] memRdata;
    logic       memReady;
    logic [7:0] aluRes;
    logic       step;
    logic       memRd;
    logic       memWr;
    logic [7:0] memAddr;
    logic [7:0] opr;
    logic [1:0] aluOp;
    logic       accWe;
    logic       jmp;
    logic       pcInc;
    logic [7:0] pc;
    logic       halted;

    int checks = 0;
    int errors = 0;

    logic [7:0] pcM;
    logic [7:0] oprM;

    instr_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .mem_rdata (memRdata),
        .mem_ready (memReady),
        .alu_res   (aluRes),
        .step      (step),
        .mem_rd    (memRd),
        .mem_wr    (memWr),
        .mem_addr  (memAddr),
        .opr       (opr),
        .alu_op    (aluOp),
        .acc_we    (accWe),
        .jmp       (jmp),
        .pc_inc    (pcInc),
        .pc        (pc),
        .halted    (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkByte(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkIdle(input string tag);
        checkBit({tag, ".rd"}, memRd, 1'b0);
        checkBit({tag, ".wr"}, memWr, 1'b0);
        checkBit({tag, ".accwe"}, accWe, 1'b0);
        checkByte({tag, ".aluop"}, {6'b0, aluOp}, 8'h03);
        checkBit({tag, ".jmp"}, jmp, 1'b0);
        checkBit({tag, ".pcinc"}, pcInc, 1'b1);
    endtask

    task automatic doReset();
        rst      = 1'b1;
        step     = 1'b1;
        memReady = 1'($urandom_range(0, 1));
        nextCycle();
        @(negedge clk);
        checkIdle("reset");
        checkBit("reset.halted", halted, 1'b0);
        checkByte("reset.pc", pc, 8'h00);
        checkByte("reset.opr", opr, 8'h00);
        rst      = 1'b0;
        step     = 1'b0;
        memReady = 1'b0;
        nextCycle();
        pcM  = 8'h00;
        oprM = 8'h00;
    endtask

    // One read transfer at the model's pc, stalled for 'waits' cycles before the ready cycle.
    task automatic doFetch(input string tag, input logic [7:0] data, input int waits);
        for (int i = 0; i <= waits; i++) begin
            memReady = (i == waits);
            memRdata = (i == waits) ? data : 8'($urandom);
            @(negedge clk);
            checkBit({tag, ".rd"}, memRd, 1'b1);
            checkBit({tag, ".wr"}, memWr, 1'b0);
            checkByte({tag, ".addr"}, memAddr, pcM);
            checkByte({tag, ".pc"}, pc, pcM);
            checkBit({tag, ".accwe"}, accWe, 1'b0);
            nextCycle();
        end
        memReady = 1'b0;
        pcM = pcM + 8'd1;
    endtask

    task automatic applyStimulus(input logic [7:0] ir, input logic [7:0] operand, input logic [7:0] alu,
                                 input int fWait, input int oWait, input int sWait, input int pauseN);
        logic [3:0] op;
        logic       taken;
        op = ir[7:4];
        doFetch("fetch", ir, fWait);
        if (op >= 4'h1 && op <= 4'h6) begin
            doFetch("fetch2", operand, oWait);
            oprM = operand;
        end
        aluRes = alu;
        case (op)
            4'h1, 4'h2, 4'h3: begin
                memReady = 1'($urandom_range(0, 1));
                @(negedge clk);
                checkBit("alu.accwe", accWe, 1'b1);
                checkByte("alu.aluop", {6'b0, aluOp}, 8'(op - 4'd1));
                checkByte("alu.opr", opr, oprM);
                checkBit("alu.rd", memRd, 1'b0);
                checkBit("alu.wr", memWr, 1'b0);
                checkByte("alu.pc", pc, pcM);
                nextCycle();
            end
            4'h4: begin
                for (int i = 0; i <= sWait; i++) begin
                    memReady = (i == sWait);
                    @(negedge clk);
                    checkBit("sta.wr", memWr, 1'b1);
                    checkBit("sta.rd", memRd, 1'b0);
                    checkByte("sta.addr", memAddr, oprM);
                    checkBit("sta.accwe", accWe, 1'b0);
                    checkByte("sta.aluop", {6'b0, aluOp}, 8'h03);
                    nextCycle();
                end
            end
            4'h5, 4'h6: begin
                taken = (op == 4'h5) || (alu != 8'h00);
                memReady = 1'($urandom_range(0, 1));
                @(negedge clk);
                checkBit("jump.jmp", jmp, taken);
                checkBit("jump.pcinc", pcInc, !taken);
                checkBit("jump.rd", memRd, 1'b0);
                checkByte("jump.pc", pc, pcM);
                nextCycle();
                if (taken) pcM = oprM;
            end
            4'hF: begin
                memReady = 1'($urandom_range(0, 1));
                @(negedge clk);
                checkIdle("hlt");
                nextCycle();
            end
            default: begin
                memReady = 1'($urandom_range(0, 1));
                @(negedge clk);
                checkIdle("nop");
                checkByte("nop.pc", pc, pcM);
                nextCycle();
            end
        endcase
        memReady = 1'b0;
`ifdef SEQ_STEP_EN
        if (op != 4'hF) begin
            step = 1'b0;
            for (int i = 0; i < pauseN; i++) begin
                memReady = 1'($urandom_range(0, 1));
                @(negedge clk);
                checkIdle("pause");
                checkByte("pause.pc", pc, pcM);
                nextCycle();
            end
            step = 1'b1;
            @(negedge clk);
            checkBit("pause.steprd", memRd, 1'b0);
            nextCycle();
            step = 1'b0;
            memReady = 1'b0;
        end
`else
        checkBit("nopause.idle", 1'(pauseN < 0), 1'b0);
`endif
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] expPc);
        #1;
        checkByte(tag, pc, expPc);
        checkByte({tag, ".model"}, pc, pcM);
    endtask

    initial begin
        logic [3:0] rop;
        rst = 1'b1; memRdata = 8'h00; memReady = 1'b0; aluRes = 8'h00; step = 1'b0;
        pcM = 8'h00; oprM = 8'h00;

        doReset();

        applyStimulus(8'h10, 8'h05, 8'h00, 0, 0, 0, 0);
        applyStimulus(8'h20, 8'h03, 8'h00, 0, 0, 0, 0);
        checkOutput("ldi_addi.pc", 8'h04);

        doReset();
        applyStimulus(8'h60, 8'h08, 8'h00, 0, 0, 0, 1);
        checkOutput("jnz_nt.pc", 8'h02);
        doReset();
        applyStimulus(8'h60, 8'h08, 8'h01, 0, 0, 0, 1);
        checkOutput("jnz_t.pc", 8'h08);

        // Three not-ready cycles on the opcode fetch, then on the operand fetch
        applyStimulus(8'h31, 8'h7A, 8'h00, 3, 3, 0, 2);
        applyStimulus(8'h40, 8'h99, 8'h00, 1, 0, 3, 5);

        doReset();
        applyStimulus(8'h50, 8'hFE, 8'h00, 0, 0, 0, 0);
        applyStimulus(8'h55, 8'hFF, 8'h00, 0, 1, 0, 0);
        applyStimulus(8'h00, 8'h00, 8'h00, 1, 0, 0, 0);
        checkOutput("wrap.pc", 8'h00);

        for (int n = 0; n < 40; n++) begin
            rop = 4'($urandom_range(0, 14));
            applyStimulus({rop, 4'($urandom)}, 8'($urandom),
                          ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom_range(1, 255)),
                          $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
                          $urandom_range(0, 2));
        end

        applyStimulus(8'hF0, 8'h00, 8'h00, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            memReady = 1'($urandom_range(0, 1));
            @(negedge clk);
            checkBit("halt.halted", halted, 1'b1);
            checkByte("halt.pc", pc, pcM);
            checkBit("halt.rd", memRd, 1'b0);
            checkBit("halt.wr", memWr, 1'b0);
            nextCycle();
        end
        doReset();

        // Reset in the middle of a stalled store abandons it
        doFetch("fetch", 8'h40, 0);
        doFetch("fetch2", 8'h33, 0);
        memReady = 1'b0;
        @(negedge clk);
        checkBit("midsta.wr", memWr, 1'b1);
        nextCycle();
        doReset();
        applyStimulus(8'h10, 8'h44, 8'h00, 0, 0, 0, 5);
        checkOutput("after_rst.pc", 8'h02);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
